// File: rtl/axis_frame_checker.sv
// AXI4-Stream sink that checks an incrementing sample stream against fixed-length framing.
// Backpressure comes from a free-running 6-bit XNOR LFSR; error pulses and counters are all registered.
module axis_frame_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 64,
    parameter int CNT_WIDTH  = 32,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                    s_axis_aclk,
    input  logic                    s_axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    input  logic                    bp_enable,
    input  logic                    clear,
    output logic                    locked,
    output logic                    data_err,
    output logic                    tlast_err,
    output logic                    strb_err,
    output logic                    sticky_err,
    output logic [CNT_WIDTH-1:0]    frame_count,
    output logic [ERR_WIDTH-1:0]    data_err_count,
    output logic [ERR_WIDTH-1:0]    tlast_err_count
);

    localparam int POS_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME_LEN - 1);

    typedef enum logic {SYNC, LOCKED} state_t;

    state_t                 state_q, state_d;
    logic [5:0]             lfsr_q, lfsr_d;
    logic                   tready_q, tready_d;
    logic [POS_W-1:0]       pos_q, pos_d;
    logic [DATA_WIDTH-1:0]  exp_q, exp_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic [ERR_WIDTH-1:0]   derr_cnt_q, derr_cnt_d;
    logic [ERR_WIDTH-1:0]   terr_cnt_q, terr_cnt_d;
    logic                   derr_q, derr_d;
    logic                   terr_q, terr_d;
    logic                   serr_q, serr_d;
    logic                   sticky_q, sticky_d;
    logic                   beat;
    logic                   at_last;

    assign beat    = s_axis_tvalid & tready_q;
    assign at_last = (pos_q == LAST_POS);

    always_comb begin
        lfsr_d      = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4] ^ 1'b1};
        tready_d    = bp_enable ? lfsr_d[5] : 1'b1;
        state_d     = state_q;
        pos_d       = pos_q;
        exp_d       = exp_q;
        frame_cnt_d = frame_cnt_q;
        derr_cnt_d  = derr_cnt_q;
        terr_cnt_d  = terr_cnt_q;
        derr_d      = 1'b0;
        terr_d      = 1'b0;
        serr_d      = 1'b0;
        sticky_d    = sticky_q;

        // clear wins over a coincident beat; that beat is swallowed unchecked
        if (clear) begin
            state_d     = SYNC;
            pos_d       = '0;
            frame_cnt_d = '0;
            derr_cnt_d  = '0;
            terr_cnt_d  = '0;
            sticky_d    = 1'b0;
        end else if (beat) begin
            case (state_q)
                SYNC: begin
                    if (s_axis_tlast) begin
                        exp_d   = s_axis_tdata + 1'b1;
                        pos_d   = '0;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    exp_d  = s_axis_tdata + 1'b1;
                    derr_d = (s_axis_tdata != exp_q);
                    terr_d = s_axis_tlast ^ at_last;
                    serr_d = ~((&s_axis_tstrb) & (&s_axis_tkeep));
                    pos_d  = (s_axis_tlast || at_last) ? '0 : pos_q + 1'b1;
                    if (s_axis_tlast && !(&frame_cnt_q)) frame_cnt_d = frame_cnt_q + 1'b1;
                    if (derr_d && !(&derr_cnt_q))        derr_cnt_d  = derr_cnt_q + 1'b1;
                    if (terr_d && !(&terr_cnt_q))        terr_cnt_d  = terr_cnt_q + 1'b1;
                    sticky_d = sticky_q | derr_d | terr_d | serr_d;
                end
                default: state_d = SYNC;
            endcase
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q     <= SYNC;
            lfsr_q      <= 6'b100000;
            tready_q    <= 1'b0;
            pos_q       <= '0;
            exp_q       <= '0;
            frame_cnt_q <= '0;
            derr_cnt_q  <= '0;
            terr_cnt_q  <= '0;
            derr_q      <= 1'b0;
            terr_q      <= 1'b0;
            serr_q      <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            tready_q    <= tready_d;
            pos_q       <= pos_d;
            exp_q       <= exp_d;
            frame_cnt_q <= frame_cnt_d;
            derr_cnt_q  <= derr_cnt_d;
            terr_cnt_q  <= terr_cnt_d;
            derr_q      <= derr_d;
            terr_q      <= terr_d;
            serr_q      <= serr_d;
            sticky_q    <= sticky_d;
        end
    end

    assign s_axis_tready   = tready_q;
    assign locked          = (state_q == LOCKED);
    assign data_err        = derr_q;
    assign tlast_err       = terr_q;
    assign strb_err        = serr_q;
    assign sticky_err      = sticky_q;
    assign frame_count     = frame_cnt_q;
    assign data_err_count  = derr_cnt_q;
    assign tlast_err_count = terr_cnt_q;

endmodule

// File: doc/axis_frame_checker.md
Name: axis_frame_checker

Overview:
- AXI4-Stream slave that sits directly downstream of axis_master_adc and consumes its 16-bit sample stream.
- Applies optional pseudo-random backpressure via s_axis_tready.
- Checks that accepted samples increment by one and that tlast marks every FRAME_LEN-th beat.
- Reports frame and error counters for on-chip diagnostics and ILA capture.

Parameters:
- DATA_WIDTH, 16, tdata width in bits; tstrb/tkeep width is DATA_WIDTH/8.
- FRAME_LEN, 64, beats per frame; power of two, 2..65536.
- CNT_WIDTH, 32, width of frame_count.
- ERR_WIDTH, 16, width of each error counter.

Ports:
- s_axis_aclk  in  1  single clock for the whole block.
- s_axis_aresetn  in  1  reset, asynchronous assert, active-low.
- s_axis_tdata  in  DATA_WIDTH  sample data.
- s_axis_tstrb  in  DATA_WIDTH/8  byte strobes.
- s_axis_tkeep  in  DATA_WIDTH/8  byte keeps.
- s_axis_tvalid  in  1  upstream data valid.
- s_axis_tlast  in  1  frame end marker.
- s_axis_tready  out  1  registered ready.
- bp_enable  in  1  1 = LFSR backpressure, 0 = always ready.
- clear  in  1  synchronous clear of counters, flags and lock.
- locked  out  1  checker synchronised to frame boundaries.
- data_err  out  1  one-cycle pulse on data mismatch.
- tlast_err  out  1  one-cycle pulse on tlast misplacement.
- strb_err  out  1  one-cycle pulse on tstrb/tkeep not all ones.
- sticky_err  out  1  OR of all error pulses since reset or clear.
- frame_count  out  CNT_WIDTH  tlast beats accepted while locked.
- data_err_count  out  ERR_WIDTH  data mismatches.
- tlast_err_count  out  ERR_WIDTH  tlast misplacements.

Behaviour:
- Reset (s_axis_aresetn=0, asynchronous): every output is 0; lfsr=6'b100000; state=SYNC; pos=0; expected=0.
- LFSR advances every clock, independent of bp_enable: lfsr[0] <= lfsr[5]^lfsr[4]^1; lfsr[5:1] <= lfsr[4:0].
- s_axis_tready is registered and takes effect from the first clock edge after reset release:
  - bp_enable=0: tready <= 1.
  - bp_enable=1: tready <= next lfsr[5].
- A beat is tvalid&&tready at a rising edge. There is no combinational path from tvalid to tready.
- State SYNC (locked=0):
  - Non-tlast beats are consumed and ignored.
  - A tlast beat loads expected <= tdata+1 (mod 2^DATA_WIDTH), sets pos <= 0, and moves to LOCKED.
  - No counter or error output changes in SYNC.
- State LOCKED (locked=1), on each beat:
  - Data check: if tdata != expected, pulse data_err and increment data_err_count. In all cases expected <= tdata+1, so the checker resyncs after a single error. 16'hFFFF -> 16'h0000 is a valid increment.
  - tlast check: error if (tlast && pos != FRAME_LEN-1) or (!tlast && pos == FRAME_LEN-1). On error, pulse tlast_err and increment tlast_err_count.
  - pos update: pos <= 0 if tlast or pos == FRAME_LEN-1; otherwise pos+1.
  - frame_count increments on every tlast beat.
  - strb/keep check: if tstrb or tkeep != all ones, pulse strb_err. This has no counter.
- Error pulse timing: pulses are registered and high for exactly the one cycle after the offending beat edge. Counters update on that same edge.
- sticky_err sets on the same edge as any pulse.
- All counters saturate at their all-ones value and do not wrap.
- Cycles without a beat: no state change except the LFSR and tready.
- clear=1 (synchronous):
  - Zeroes counters, pulses and sticky_err; sets pos=0 and state=SYNC.
  - Has priority over a simultaneous beat; that beat is consumed but not checked.
  - The LFSR is not affected.
- Reset asserted mid-frame: immediate return to reset values; tready drops asynchronously.
- Simultaneous data and tlast errors on one beat: both pulses fire and both counters increment.

Test Plan:
- Reset release, bp_enable=0, upstream sends tdata 0..255 with tlast on tdata 63/127/191/255 -> tready=1 from the first edge after release; lock on beat 63; frame_count=3; no error pulses; sticky_err=0.
- bp_enable=1, same stream -> tready follows the LFSR sequence from seed 6'b100000; no beat lost or duplicated; frame_count=3; error counters=0.
- Locked stream 100,101,103,104 -> exactly one data_err pulse, on the beat carrying 103; data_err_count=1; the 104 beat passes.
- Locked stream with tlast moved from pos 63 to pos 62 -> tlast_err pulses at pos 62 (early tlast); the next frame is realigned and the 63rd beat after the early tlast is clean; tlast_err_count=1.
- tdata wraps 16'hFFFE,16'hFFFF,16'h0000 while locked -> no data_err; tkeep=2'b01 on one beat -> one strb_err pulse and sticky_err=1.
- Force data_err_count to 16'hFFFF, inject one more data error, then assert clear for one cycle alongside a valid beat -> counter holds 16'hFFFF before clear; after clear all counters=0, locked=0, and that beat is not counted.
